// File: rtl/control_unit.sv
// control_unit -- Moore sequencer for a small accumulator datapath.
// Each instruction runs START -> FETCH -> DECODE -> execute (4 cycles);
// HALT is terminal until clear is asserted.
// Optional build macro CU_INPUT_WAIT_EN: INPUT waits for the operator
// Enter strobe before loading A. Without it, Enter is ignored.
//
// state   | code | meaning
// START   | 0000 | idle cycle between instructions, all strobes low
// FETCH   | 0001 | load IR from memory, increment PC
// DECODE  | 0010 | present instruction address, branch on IR75
// LOAD    | 1000 | A <- RAM
// STORE   | 1001 | RAM <- A
// ADD     | 1010 | A <- A + RAM
// SUB     | 1011 | A <- A - RAM
// INPUT   | 1100 | A <- external input
// JZ      | 1101 | PC <- IR address if A == 0
// JPOS    | 1110 | PC <- IR address if A > 0
// HALT    | 1111 | stopped until clear
module control_unit (
   input  logic       clk,
   input  logic       clear,
   input  logic [2:0] IR75,
   input  logic       Aeq0,
   input  logic       Apos,
   input  logic       Enter,
   output logic       IRload,
   output logic       JMPmux,
   output logic       PCload,
   output logic       Meminst,
   output logic       MemWr,
   output logic       Aload,
   output logic       Sub,
   output logic [1:0] Asel,
   output logic       Halt,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      ST_START  = 4'b0000,
      ST_FETCH  = 4'b0001,
      ST_DECODE = 4'b0010,
      ST_LOAD   = 4'b1000,
      ST_STORE  = 4'b1001,
      ST_ADD    = 4'b1010,
      ST_SUB    = 4'b1011,
      ST_INPUT  = 4'b1100,
      ST_JZ     = 4'b1101,
      ST_JPOS   = 4'b1110,
      ST_HALT   = 4'b1111
   } state_t;

   state_t state_q;
   state_t state_d;

`ifndef CU_INPUT_WAIT_EN
   logic unused_enter;
   assign unused_enter = Enter;
`endif

   // State register; clear forces START immediately, so every decoded strobe drops with it.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= ST_START;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore output decode (PCload in JZ/JPOS also follows the flags).
   always_comb begin
      state_d = state_q;
      IRload  = 1'b0;
      JMPmux  = 1'b0;
      PCload  = 1'b0;
      Meminst = 1'b0;
      MemWr   = 1'b0;
      Aload   = 1'b0;
      Sub     = 1'b0;
      Asel    = 2'd0;
      Halt    = 1'b0;
      case (state_q)
         ST_START: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            IRload  = 1'b1;
            PCload  = 1'b1;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            Meminst = 1'b1;
            state_d = state_t'({1'b1, IR75});
         end
         ST_LOAD: begin
            Asel    = 2'd2;
            Aload   = 1'b1;
            state_d = ST_START;
         end
         ST_STORE: begin
            Meminst = 1'b1;
            MemWr   = 1'b1;
            state_d = ST_START;
         end
         ST_ADD: begin
            Aload   = 1'b1;
            state_d = ST_START;
         end
         ST_SUB: begin
            Aload   = 1'b1;
            Sub     = 1'b1;
            state_d = ST_START;
         end
         ST_INPUT: begin
            Asel = 2'd1;
`ifdef CU_INPUT_WAIT_EN
            // Select stays on the external input while waiting; only the load waits.
            if (Enter) begin
               Aload   = 1'b1;
               state_d = ST_START;
            end
`else
            Aload   = 1'b1;
            state_d = ST_START;
`endif
         end
         ST_JZ: begin
            JMPmux  = 1'b1;
            PCload  = Aeq0;
            state_d = ST_START;
         end
         ST_JPOS: begin
            JMPmux  = 1'b1;
            PCload  = Apos;
            state_d = ST_START;
         end
         ST_HALT: begin
            Halt    = 1'b1;
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_START;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- random instruction streams checked against a per-instruction
// expected trace (sequence of state codes) and a table of outputs per state.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       clear;
   logic [2:0] IR75;
   logic       Aeq0, Apos, Enter;
   logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
   logic [1:0] Asel;
   logic [3:0] state;

   int checks_cnt = 0;
   int errors_cnt = 0;

   typedef struct {
      int code;   // expected state code for this cycle
      int ir;     // opcode to present (-1: random)
      int flag;   // forced Aeq0/Apos value (-1: random)
      bit enter;
   } cyc_t;

   typedef struct packed {
      logic irload, jmpmux, pcload, meminst, memwr, aload, sub;
      logic [1:0] asel;
      logic halt;
   } out_t;

   cyc_t trace[$];

   control_unit dut (
      .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
      .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
      .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks_cnt++;
      if (got != exp) begin
         errors_cnt++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // What each state must drive, straight from the state/strobe table.
   function automatic out_t exp_out(input int code, input bit aeq, input bit apos, input bit ent);
      out_t o;
      o = '0;
      case (code)
         1:  begin o.irload = 1; o.pcload = 1; end
         2:  o.meminst = 1;
         8:  begin o.asel = 2; o.aload = 1; end
         9:  begin o.meminst = 1; o.memwr = 1; end
         10: o.aload = 1;
         11: begin o.aload = 1; o.sub = 1; end
         12: begin
            o.asel = 1;
`ifdef CU_INPUT_WAIT_EN
            o.aload = ent;
`else
            o.aload = 1;
`endif
         end
         13: begin o.jmpmux = 1; o.pcload = aeq; end
         14: begin o.jmpmux = 1; o.pcload = apos; end
         15: o.halt = 1;
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic check_outputs(input string where, input int code);
      out_t e;
      e = exp_out(code, Aeq0, Apos, Enter);
      check({where, ".state"},   state,   code);
      check({where, ".IRload"},  IRload,  e.irload);
      check({where, ".JMPmux"},  JMPmux,  e.jmpmux);
      check({where, ".PCload"},  PCload,  e.pcload);
      check({where, ".Meminst"}, Meminst, e.meminst);
      check({where, ".MemWr"},   MemWr,   e.memwr);
      check({where, ".Aload"},   Aload,   e.aload);
      check({where, ".Sub"},     Sub,     e.sub);
      check({where, ".Asel"},    Asel,    e.asel);
      check({where, ".Halt"},    Halt,    e.halt);
   endtask

   // Drive one cycle's inputs (IR75 and flags random unless pinned) and check outputs.
   task automatic drive_check(input cyc_t c);
      IR75 = 3'($urandom);
      Aeq0 = 1'($urandom);
      Apos = 1'($urandom);
`ifdef CU_INPUT_WAIT_EN
      Enter = c.enter;
`else
      Enter = 1'($urandom);
`endif
      if (c.ir >= 0) IR75 = 3'(c.ir);
      if (c.flag >= 0) begin
         Aeq0 = 1'(c.flag);
         Apos = 1'(c.flag);
      end
      #1;
      check_outputs("cyc", c.code);
   endtask

   task automatic play_trace();
      while (trace.size() > 0) begin
         drive_check(trace.pop_front());
         @(posedge clk);
         #1;
      end
   endtask

   // Expected cycles of one instruction, starting from its START cycle.
   task automatic push_instr(input int op, input int flag);
      trace.push_back('{0, -1, -1, 1'b0});
      trace.push_back('{1, -1, -1, 1'b0});
      trace.push_back('{2, op, -1, 1'b0});
`ifdef CU_INPUT_WAIT_EN
      if (op == 4) begin
         for (int k = 0; k < 3; k++) trace.push_back('{12, -1, -1, 1'b0});
      end
`endif
      trace.push_back('{8 + op, -1, flag, 1'b1});
      if (op == 7) begin
         for (int k = 0; k < 10; k++) trace.push_back('{15, -1, -1, 1'b0});
      end
   endtask

   task automatic run_instr(input int op, input int flag);
      push_instr(op, flag);
      play_trace();
   endtask

   // Assert clear between edges and expect an immediate return to START, then release.
   task automatic mid_cycle_reset(input string where);
      #2;
      clear = 1'b0;
      #1;
      check_outputs(where, 0);
      @(posedge clk);
      #1;
      check_outputs(where, 0);
      @(negedge clk);
      clear = 1'b1;
   endtask

   initial begin
      clear = 1'b0;
      IR75 = 3'b111; Aeq0 = 1'b1; Apos = 1'b1; Enter = 1'b1;
      #1;
      check_outputs("reset", 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_outputs("reset_hold", 0);
      @(negedge clk);
      clear = 1'b1;

      // Directed: LOAD, ADD, SUB, STORE, jumps with both flag values, INPUT.
      run_instr(0, -1);
      run_instr(2, -1);
      run_instr(3, -1);
      run_instr(1, -1);
      run_instr(5, 1);
      run_instr(5, 0);
      run_instr(6, 1);
      run_instr(6, 0);
      run_instr(4, -1);

      // Abort a STORE in its execute cycle: MemWr must vanish with the reset.
      trace.push_back('{0, -1, -1, 1'b0});
      trace.push_back('{1, -1, -1, 1'b0});
      trace.push_back('{2, 1, -1, 1'b0});
      play_trace();
      drive_check('{9, -1, -1, 1'b0});
      mid_cycle_reset("abort");

      // Random instruction stream, excluding HALT.
      for (int n = 0; n < 40; n++) run_instr(int'($urandom_range(0, 6)), -1);

      // HALT holds for 10 cycles whatever IR75 does, then clear recovers.
      run_instr(7, -1);
      drive_check('{15, -1, -1, 1'b0});
      mid_cycle_reset("halt_clear");
      run_instr(int'($urandom_range(0, 6)), -1);
      run_instr(0, -1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
- REQ-001 The block SHALL have no parameters; all widths are fixed.
- REQ-002 clk  input  1  single system clock; all state changes on rising edge.
- REQ-003 clear  input  1  reset, asynchronous, active-low.
- REQ-004 IR75  input  3  opcode field from the datapath instruction register.
- REQ-005 Aeq0  input  1  datapath flag: accumulator A == 0.
- REQ-006 Apos  input  1  datapath flag: accumulator A > 0 (signed).
- REQ-007 Enter  input  1  operator-input strobe, used only when CU_INPUT_WAIT_EN is defined.
- REQ-008 IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub  output  1 each  datapath control strobes.
- REQ-009 Asel  output  2  A-source select: 0 = ALU, 1 = external in, 2 = RAM; 3 is never driven.
- REQ-010 Halt  output  1  high while in HALT.
- REQ-011 state  output  4  current state code, for debug.

Function
- REQ-012 Moore FSM; all outputs SHALL decode from the registered state only, except PCload in JZ/JPOS.
- REQ-013 State codes SHALL be START=0000, FETCH=0001, DECODE=0010, LOAD=1000, STORE=1001, ADD=1010, SUB=1011, INPUT=1100, JZ=1101, JPOS=1110, HALT=1111.
- REQ-014 START SHALL drive all strobes 0 and Asel=0, then go to FETCH.
- REQ-015 FETCH SHALL drive IRload=1, PCload=1, JMPmux=0, then go to DECODE.
- REQ-016 DECODE SHALL drive Meminst=1.
- REQ-017 DECODE SHALL branch on IR75 to the execute state with code {1,IR75}: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
- REQ-018 LOAD SHALL drive Asel=2, Aload=1.
- REQ-019 STORE SHALL drive Meminst=1, MemWr=1.
- REQ-020 ADD SHALL drive Asel=0, Aload=1, Sub=0.
- REQ-021 SUB SHALL drive Asel=0, Aload=1, Sub=1.
- REQ-022 INPUT SHALL drive Asel=1, Aload=1.
- REQ-023 JZ SHALL drive JMPmux=1 and PCload=Aeq0.
- REQ-024 JPOS SHALL drive JMPmux=1 and PCload=Apos.
- REQ-025 Each execute state except HALT SHALL last exactly one cycle and return to START; one instruction therefore takes 4 cycles.
- REQ-026 HALT SHALL drive all strobes 0 and Halt=1, and remain in HALT until clear is asserted.
- REQ-027 In any state, any strobe not listed for that state SHALL be 0; MemWr SHALL never be 1 outside STORE.
- REQ-028 IR75, Aeq0 and Apos SHALL be ignored in every state other than those that sample them.

Reset
- REQ-029 clear=0 SHALL immediately force state=START, all strobes 0, Asel=0 and Halt=0, regardless of clk.
- REQ-030 Reset asserted mid-instruction SHALL abort the instruction with no partial strobe.
- REQ-031 On clear release, the first rising edge SHALL move the FSM to FETCH.

Configuration
- REQ-032 Macro CU_INPUT_WAIT_EN: when defined, INPUT SHALL hold with Aload=0 until Enter=1.
- REQ-033 With CU_INPUT_WAIT_EN, the cycle with Enter=1 SHALL assert Aload=1 and Asel=1, then go to START.
- REQ-034 Without CU_INPUT_WAIT_EN, Enter SHALL be ignored and INPUT SHALL behave per REQ-022 (one cycle).

Verification
- REQ-035 Hold clear=0 for 2 cycles, then release -> state=0000 and all outputs 0 during reset; FETCH follows with IRload=PCload=1.
- REQ-036 IR75=000, then 010, then 011 on successive instructions -> state sequence 0000,0001,0010,1000 then ...1010 then ...1011, with Asel=2/0/0 and Sub=0/0/1.
- REQ-037 IR75=001 -> MemWr=1 and Meminst=1 for exactly one cycle (state 1001); MemWr=0 in every other cycle.
- REQ-038 IR75=101 with Aeq0=1 -> PCload=1, JMPmux=1; repeat with Aeq0=0 -> PCload=0. Same check for IR75=110 using Apos.
- REQ-039 IR75=111 -> state=1111 and Halt=1, held for 10 cycles regardless of IR75; assert clear=0 mid-cycle -> immediate START.
- REQ-040 With CU_INPUT_WAIT_EN defined, IR75=100 and Enter=0 for 3 cycles -> state=1100 with Aload=0 throughout; Enter=1 -> Aload=1, Asel=1, then START.
